// File: rtl/paddle_input_ctrl.sv
// Button synchroniser/debouncer and paddle position generator for the two-player game.
// Optional build macro AUTO_P2_EN lets player 2 track ball_y automatically while ai_en is high.
module paddle_input_ctrl #(
    parameter int Y_MIN      = 60,
    parameter int Y_MAX      = 420,
    parameter int Y_RESET    = 240,
    parameter int STEP_DIV   = 100000,
    parameter int DEB_CYCLES = 50000,
    parameter int STEP_FAST  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  btn_up_raw,
    input  logic [1:0]  btn_dn_raw,
    input  logic        fast,
    input  logic        recentre,
    input  logic        ai_en,
    input  logic [10:0] ball_y,
    output logic [3:0]  btn_state,
    output logic [10:0] p1_y,
    output logic [10:0] p2_y
);

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TICK_W = $clog2(STEP_DIV);

    logic [3:0] raw_vec;
    logic [3:0] btn_acc;

    assign raw_vec = {btn_dn_raw[1], btn_up_raw[1], btn_dn_raw[0], btn_up_raw[0]};

    // Per button: two-flop synchroniser, then accept a new level only after it has been stable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic             s1_q, s1_d, s2_q, s2_d, acc_q, acc_d;
            logic [DEB_W-1:0] cnt_q, cnt_d;

            always_comb begin
                s1_d  = raw_vec[gi];
                s2_d  = s1_q;
                acc_d = acc_q;
                cnt_d = '0;
                if (s2_q != acc_q) begin
                    if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
                        acc_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    s1_q  <= 1'b0;
                    s2_q  <= 1'b0;
                    acc_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    s1_q  <= s1_d;
                    s2_q  <= s2_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                end
            end

            assign btn_acc[gi] = acc_q;
        end
    endgenerate

    // 12-bit arithmetic keeps y+step and Y_MIN+step free of wrap before clamping.
    function automatic logic [11:0] move_y(input logic [11:0] y, input logic up,
                                           input logic dn, input logic [11:0] step);
        logic [11:0] r;
        r = y;
        if (up && !dn) begin
            r = (y < 12'(Y_MIN) + step) ? 12'(Y_MIN) : y - step;
        end else if (dn && !up) begin
            r = (y + step > 12'(Y_MAX)) ? 12'(Y_MAX) : y + step;
        end
        return r;
    endfunction

`ifdef AUTO_P2_EN
    function automatic logic [11:0] track_y(input logic [11:0] y, input logic [11:0] tgt,
                                            input logic [11:0] step);
        logic [11:0] r;
        r = y;
        if (tgt < y) begin
            r = (y - tgt < step) ? tgt : y - step;
        end else if (tgt > y) begin
            r = (tgt - y < step) ? tgt : y + step;
        end
        if (r < 12'(Y_MIN)) r = 12'(Y_MIN);
        if (r > 12'(Y_MAX)) r = 12'(Y_MAX);
        return r;
    endfunction
`else
    logic unused_inputs;
    assign unused_inputs = ^{ai_en, ball_y};
`endif

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [10:0]       p1_q, p1_d, p2_q, p2_d;
    logic              tick;
    logic [11:0]       step;

    assign tick = (tick_cnt_q == TICK_W'(STEP_DIV - 1));
    assign step = fast ? 12'(STEP_FAST) : 12'd1;

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        p1_d       = p1_q;
        p2_d       = p2_q;
        if (recentre) begin
            p1_d = 11'(Y_RESET);
            p2_d = 11'(Y_RESET);
        end else if (tick) begin
            p1_d = 11'(move_y({1'b0, p1_q}, btn_acc[0], btn_acc[1], step));
`ifdef AUTO_P2_EN
            if (ai_en) begin
                p2_d = 11'(track_y({1'b0, p2_q}, {1'b0, ball_y}, step));
            end else begin
                p2_d = 11'(move_y({1'b0, p2_q}, btn_acc[2], btn_acc[3], step));
            end
`else
            p2_d = 11'(move_y({1'b0, p2_q}, btn_acc[2], btn_acc[3], step));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt_q <= '0;
            p1_q       <= 11'(Y_RESET);
            p2_q       <= 11'(Y_RESET);
        end else begin
            tick_cnt_q <= tick_cnt_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
        end
    end

    assign btn_state = btn_acc;
    assign p1_y      = p1_q;
    assign p2_y      = p2_q;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Directed bench for paddle_input_ctrl with STEP_DIV=4, DEB_CYCLES=3.
// Edge k counts posedges since reset release; ticks fall on edges with k%4==0.
module tb_paddle_input_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  btn_up_raw, btn_dn_raw;
    logic        fast, recentre, ai_en;
    logic [10:0] ball_y;
    logic [3:0]  btn_state;
    logic [10:0] p1_y, p2_y;

    int compares = 0;
    int fails    = 0;
    int edge_cnt = 0;

    paddle_input_ctrl #(
        .Y_MIN(60), .Y_MAX(420), .Y_RESET(240),
        .STEP_DIV(4), .DEB_CYCLES(3), .STEP_FAST(2)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up_raw(btn_up_raw), .btn_dn_raw(btn_dn_raw),
        .fast(fast), .recentre(recentre), .ai_en(ai_en), .ball_y(ball_y),
        .btn_state(btn_state), .p1_y(p1_y), .p2_y(p2_y)
    );

    always #5 clk = ~clk;

    task automatic run_to(input int k);
        while (edge_cnt < k) begin
            @(posedge clk);
            edge_cnt++;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, edge_cnt, obs, exp);
        end
        $display("check %-12s edge %0d observed %0d expected %0d", tag, edge_cnt, obs, exp);
    endtask

    initial begin
        // Reset with every button pressed
        rst = 1'b0; btn_up_raw = 2'b11; btn_dn_raw = 2'b11;
        fast = 1'b0; recentre = 1'b0; ai_en = 1'b0; ball_y = 11'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; btn_up_raw = 2'b01; btn_dn_raw = 2'b00;
        edge_cnt = 0;
        chk("rst_p1", p1_y, 11'd240);
        chk("rst_p2", p2_y, 11'd240);
        chk("rst_btn", {7'd0, btn_state}, 11'd0);

        // P1 up held, slow
        run_to(4);  chk("deb_early", {7'd0, btn_state}, 11'd0);
                    chk("p1_hold4", p1_y, 11'd240);
        run_to(5);  chk("deb_accept", {7'd0, btn_state}, 11'd1);
        run_to(8);  chk("p1_239", p1_y, 11'd239);
        run_to(12); chk("p1_238", p1_y, 11'd238);
                    chk("p2_still", p2_y, 11'd240);
        btn_up_raw[0] = 1'b0;
        run_to(16); chk("p1_237", p1_y, 11'd237);
        run_to(17); chk("deb_release", {7'd0, btn_state}, 11'd0);

        // Two-cycle glitch must never be accepted
        btn_up_raw[0] = 1'b1;
        run_to(19); btn_up_raw[0] = 1'b0;
        for (int k = 20; k <= 24; k++) begin
            run_to(k); chk("glitch_btn", {7'd0, btn_state}, 11'd0);
        end
        chk("glitch_p1", p1_y, 11'd237);

        // Fast run to both clamps
        btn_up_raw[0] = 1'b1; btn_dn_raw[1] = 1'b1; fast = 1'b1;
        run_to(32);  chk("p2_242", p2_y, 11'd242);
                     chk("p1_235", p1_y, 11'd235);
        run_to(380); chk("p1_61", p1_y, 11'd61);
                     chk("p2_416", p2_y, 11'd416);
        run_to(384); chk("p1_min", p1_y, 11'd60);
                     chk("p2_418", p2_y, 11'd418);
        run_to(388); chk("p2_max", p2_y, 11'd420);
        run_to(400); chk("p1_min_hold", p1_y, 11'd60);
                     chk("p2_max_hold", p2_y, 11'd420);

        // Both-buttons hold and recentre
        btn_up_raw[0] = 1'b0; btn_dn_raw[0] = 1'b1; btn_dn_raw[1] = 1'b0;
        run_to(408); chk("p1_62", p1_y, 11'd62);
        run_to(412); btn_up_raw[0] = 1'b1;
        run_to(416); chk("p1_66", p1_y, 11'd66);
        run_to(424); chk("p1_both", p1_y, 11'd66);
                     chk("p2_420", p2_y, 11'd420);
        btn_up_raw[0] = 1'b0;
        run_to(429); chk("btn_dn0", {7'd0, btn_state}, 11'd2);
        run_to(432); chk("p1_68", p1_y, 11'd68);
        run_to(433); recentre = 1'b1;
        run_to(434); chk("rc_p1", p1_y, 11'd240);
                     chk("rc_p2", p2_y, 11'd240);
        run_to(436); chk("rc_tick_p1", p1_y, 11'd240);
        run_to(437); recentre = 1'b0;
        run_to(438); chk("rc_off_p1", p1_y, 11'd240);
        run_to(440); chk("resume_p1", p1_y, 11'd242);
                     chk("resume_p2", p2_y, 11'd240);

        // Autopilot request with P2 up pressed
        btn_dn_raw[0] = 1'b0; btn_up_raw[1] = 1'b1; ai_en = 1'b1; ball_y = 11'd245;
`ifdef AUTO_P2_EN
        run_to(444); chk("ai_242", p2_y, 11'd242);
        run_to(448); chk("ai_244", p2_y, 11'd244);
        run_to(452); chk("ai_245", p2_y, 11'd245);
        run_to(456); chk("ai_hold", p2_y, 11'd245);
`else
        run_to(444); chk("man_240", p2_y, 11'd240);
        run_to(448); chk("man_238", p2_y, 11'd238);
        run_to(452); chk("man_236", p2_y, 11'd236);
        run_to(456); chk("man_234", p2_y, 11'd234);
`endif
        chk("ai_p1", p1_y, 11'd244);
        chk("ai_btn", {7'd0, btn_state}, 11'd4);

        // Reset mid-move
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst2_p1", p1_y, 11'd240);
        chk("rst2_p2", p2_y, 11'd240);
        chk("rst2_btn", {7'd0, btn_state}, 11'd0);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
